// File: rtl/pong_ball_if.sv
// pong_ball_if: step/serve controls, paddle positions and ball outputs
// exchanged between the game logic and the bouncing-ball block.
// master = game tick / paddle side (drives controls); slave = the ball block.
interface pong_ball_if #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 48
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic          move;
  logic          serve;
  logic          serveDir;
  logic [YW-1:0] leftPaddleTop;
  logic [YW-1:0] rightPaddleTop;
  logic [YW-1:0] top;
  logic [XW-1:0] left;
  logic [YW-1:0] bottom;
  logic [XW-1:0] right;
  logic          inPlay;
  logic          paddleHit;
  logic          scoreLeft;
  logic          scoreRight;

  modport master (
    output move, serve, serveDir, leftPaddleTop, rightPaddleTop,
    input  top, left, bottom, right, inPlay, paddleHit, scoreLeft, scoreRight
  );

  modport slave (
    input  move, serve, serveDir, leftPaddleTop, rightPaddleTop,
    output top, left, bottom, right, inPlay, paddleHit, scoreLeft, scoreRight
  );
endinterface

// File: rtl/pong_ball.sv
// pong_ball: square ball with serve / play / score sequencing, wall
// bounces and collision against two player paddles.
// Optional build macro PONG_BALL_SPEEDUP_EN: each paddle hit raises the
// horizontal speed magnitude by one, saturating at MAX_SPEED.
module pong_ball #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 48,
  parameter int SIZE       = 4,
  parameter int X_SPEED    = 2,
  parameter int Y_SPEED    = 1,
  parameter int PADDLE_X   = 2,
  parameter int PADDLE_W   = 2,
  parameter int PADDLE_H   = 12,
  parameter int SCORE_HOLD = 8,
  parameter int MAX_SPEED  = 4
) (
  input  logic       clk,
  input  logic       resetN,
  pong_ball_if.slave bus
);

  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  // Velocity register must hold +/- the largest speed that can ever be loaded.
  localparam int SPD1 = (MAX_SPEED > X_SPEED) ? MAX_SPEED : X_SPEED;
  localparam int SPD2 = (SPD1 > Y_SPEED) ? SPD1 : Y_SPEED;
  localparam int VW   = $clog2(SPD2 + 1) + 1;
  // Next-position arithmetic: sign bit plus one guard bit above the field.
  localparam int NXW  = XW + 2;
  localparam int NYW  = YW + 2;
  localparam int HW   = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;

  localparam logic [XW-1:0] CX      = XW'((WIDTH - SIZE) / 2);
  localparam logic [YW-1:0] CY      = YW'((HEIGHT - SIZE) / 2);
  localparam logic [XW-1:0] X_WALLR = XW'(WIDTH - SIZE);
  localparam logic [YW-1:0] Y_FLOOR = YW'(HEIGHT - SIZE);
  localparam logic [XW-1:0] L_STOP  = XW'(PADDLE_X + PADDLE_W);
  // Ball left column that puts its right edge exactly on the right paddle face.
  localparam logic [XW-1:0] R_STOP  = XW'(WIDTH - PADDLE_X - PADDLE_W - SIZE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SCORE_HOLD - 1);

  localparam logic signed [NXW-1:0] ZX       = '0;
  localparam logic signed [NYW-1:0] ZY       = '0;
  localparam logic signed [NXW-1:0] LF_S     = NXW'(PADDLE_X + PADDLE_W);
  localparam logic signed [NXW-1:0] RHIT_S   = NXW'(WIDTH - PADDLE_X - PADDLE_W - SIZE);
  localparam logic signed [NXW-1:0] RWALL_S  = NXW'(WIDTH - SIZE);
  localparam logic signed [NYW-1:0] YFLOOR_S = NYW'(HEIGHT - SIZE);
  localparam logic signed [NYW-1:0] PH_M1    = NYW'(PADDLE_H - 1);
  localparam logic signed [NYW-1:0] SZ_M1    = NYW'(SIZE - 1);
  localparam logic signed [VW-1:0]  XS       = VW'(X_SPEED);
  localparam logic signed [VW-1:0]  YS       = VW'(Y_SPEED);
`ifdef PONG_BALL_SPEEDUP_EN
  localparam logic signed [VW-1:0]  VMAX     = VW'(MAX_SPEED);
  localparam logic signed [VW-1:0]  ONE_V    = VW'(1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVING,
    ST_SCORED
  } state_t;

  state_t                 state_q, state_d;
  logic [XW-1:0]          left_q,  left_d;
  logic [YW-1:0]          top_q,   top_d;
  logic signed [VW-1:0]   xvel_q,  xvel_d;
  logic signed [VW-1:0]   yvel_q,  yvel_d;
  logic [HW-1:0]          hold_q,  hold_d;
  logic                   hit_q,   hit_d;
  logic                   scl_q,   scl_d;
  logic                   scr_q,   scr_d;

  logic signed [NXW-1:0]  lpos, nx, xv_ext;
  logic signed [NYW-1:0]  tpos, ny, yv_ext;
  logic signed [VW-1:0]   xmag;
  logic                   lhit, rhit;

  // Ball rows [y, y+SIZE-1] intersect paddle rows [pt, pt+PADDLE_H-1].
  function automatic logic rows_overlap(input logic signed [NYW-1:0] y,
                                        input logic [YW-1:0]         pt);
    logic signed [NYW-1:0] p;
    p = signed'({2'b00, pt});
    return (y <= p + PH_M1) && (y + SZ_M1 >= p);
  endfunction

  // Speed magnitude after a paddle bounce.
  function automatic logic signed [VW-1:0] bump_speed(input logic signed [VW-1:0] mag);
`ifdef PONG_BALL_SPEEDUP_EN
    return (mag >= VMAX) ? VMAX : mag + ONE_V;
`else
    return mag;
`endif
  endfunction

  // Next-state, next-position and event pulse decode.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    top_d   = top_q;
    xvel_d  = xvel_q;
    yvel_d  = yvel_q;
    hold_d  = hold_q;
    hit_d   = 1'b0;
    scl_d   = 1'b0;
    scr_d   = 1'b0;

    lpos   = signed'({2'b00, left_q});
    tpos   = signed'({2'b00, top_q});
    xv_ext = {{(NXW - VW){xvel_q[VW-1]}}, xvel_q};
    yv_ext = {{(NYW - VW){yvel_q[VW-1]}}, yvel_q};
    nx     = lpos + xv_ext;
    ny     = tpos + yv_ext;
    xmag   = xvel_q[VW-1] ? -xvel_q : xvel_q;

    // A paddle only catches a ball that was still in front of its face.
    lhit = (nx <= LF_S) && (lpos >= LF_S) && rows_overlap(ny, bus.leftPaddleTop);
    rhit = (nx >= RHIT_S) && (lpos <= RHIT_S) && rows_overlap(ny, bus.rightPaddleTop);

    case (state_q)
      ST_IDLE: begin
        left_d = CX;
        top_d  = CY;
        if (bus.serve) begin
          state_d = ST_MOVING;
          xvel_d  = bus.serveDir ? XS : -XS;
          yvel_d  = YS;
        end
      end

      ST_MOVING: begin
        if (bus.move) begin
          if (ny <= ZY) begin
            top_d  = '0;
            yvel_d = YS;
          end else if (ny >= YFLOOR_S) begin
            top_d  = Y_FLOOR;
            yvel_d = -YS;
          end else begin
            top_d = ny[YW-1:0];
          end

          if (xvel_q[VW-1]) begin
            if (lhit) begin
              left_d = L_STOP;
              xvel_d = bump_speed(xmag);
              hit_d  = 1'b1;
            end else if (nx <= ZX) begin
              left_d  = '0;
              scr_d   = 1'b1;
              hold_d  = '0;
              state_d = ST_SCORED;
            end else begin
              left_d = nx[XW-1:0];
            end
          end else if (xvel_q != '0) begin
            if (rhit) begin
              left_d = R_STOP;
              xvel_d = -bump_speed(xmag);
              hit_d  = 1'b1;
            end else if (nx >= RWALL_S) begin
              left_d  = X_WALLR;
              scl_d   = 1'b1;
              hold_d  = '0;
              state_d = ST_SCORED;
            end else begin
              left_d = nx[XW-1:0];
            end
          end
        end
      end

      ST_SCORED: begin
        if (bus.move) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            left_d  = CX;
            top_d   = CY;
            xvel_d  = '0;
            yvel_d  = '0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        left_d  = CX;
        top_d   = CY;
        xvel_d  = '0;
        yvel_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State, position, velocity and pulse registers; reset recentres the ball.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      left_q  <= CX;
      top_q   <= CY;
      xvel_q  <= '0;
      yvel_q  <= '0;
      hold_q  <= '0;
      hit_q   <= 1'b0;
      scl_q   <= 1'b0;
      scr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      top_q   <= top_d;
      xvel_q  <= xvel_d;
      yvel_q  <= yvel_d;
      hold_q  <= hold_d;
      hit_q   <= hit_d;
      scl_q   <= scl_d;
      scr_q   <= scr_d;
    end
  end

  assign bus.top        = top_q;
  assign bus.left       = left_q;
  assign bus.bottom     = top_q + YW'(SIZE - 1);
  assign bus.right      = left_q + XW'(SIZE - 1);
  assign bus.inPlay     = (state_q == ST_MOVING);
  assign bus.paddleHit  = hit_q;
  assign bus.scoreLeft  = scl_q;
  assign bus.scoreRight = scr_q;

endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: directed play sequences followed by randomized play, all
// checked every cycle against an integer model of the ball rules.
module tb_pong_ball;
  localparam int WIDTH = 64, HEIGHT = 48, SIZE = 4, X_SPEED = 2, Y_SPEED = 1;
  localparam int PADDLE_X = 2, PADDLE_W = 2, PADDLE_H = 12, SCORE_HOLD = 8, MAX_SPEED = 4;
  localparam int YW = $clog2(HEIGHT);
  localparam int LF = PADDLE_X + PADDLE_W;
  localparam int RF = WIDTH - 1 - PADDLE_X - PADDLE_W;
  localparam int CX = (WIDTH - SIZE) / 2;
  localparam int CY = (HEIGHT - SIZE) / 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  pong_ball_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  pong_ball #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SIZE(SIZE), .X_SPEED(X_SPEED), .Y_SPEED(Y_SPEED),
    .PADDLE_X(PADDLE_X), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
    .SCORE_HOLD(SCORE_HOLD), .MAX_SPEED(MAX_SPEED)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  // Model: mode 0 waiting for serve, 1 in play, 2 holding after a score.
  int m_mode, m_left, m_top, m_vx, m_vy, m_hold;
  int m_hit, m_sl, m_sr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ovl(input int y, input int pt);
    return (y <= pt + PADDLE_H - 1) && (y + SIZE - 1 >= pt);
  endfunction

  function automatic int faster(input int m);
`ifdef PONG_BALL_SPEEDUP_EN
    return (m + 1 > MAX_SPEED) ? MAX_SPEED : m + 1;
`else
    return m;
`endif
  endfunction

  task automatic model_step();
    int nx, ny, mag;
    m_hit = 0; m_sl = 0; m_sr = 0;
    if (!resetN) begin
      m_mode = 0; m_left = CX; m_top = CY; m_vx = 0; m_vy = 0; m_hold = 0;
    end else if (m_mode == 0) begin
      if (bus.serve) begin
        m_mode = 1;
        m_vx = bus.serveDir ? X_SPEED : -X_SPEED;
        m_vy = Y_SPEED;
      end
    end else if (m_mode == 1) begin
      if (bus.move) begin
        nx = m_left + m_vx;
        ny = m_top + m_vy;
        mag = (m_vx < 0) ? -m_vx : m_vx;
        if (ny <= 0) begin
          m_top = 0; m_vy = Y_SPEED;
        end else if (ny + SIZE - 1 >= HEIGHT - 1) begin
          m_top = HEIGHT - SIZE; m_vy = -Y_SPEED;
        end else m_top = ny;
        if (m_vx < 0) begin
          if (nx <= LF && m_left >= LF && ovl(ny, int'(bus.leftPaddleTop))) begin
            m_left = LF; m_vx = faster(mag); m_hit = 1;
          end else if (nx <= 0) begin
            m_left = 0; m_sr = 1; m_mode = 2; m_hold = SCORE_HOLD;
          end else m_left = nx;
        end else if (m_vx > 0) begin
          if (nx + SIZE - 1 >= RF && m_left + SIZE - 1 <= RF && ovl(ny, int'(bus.rightPaddleTop))) begin
            m_left = RF - SIZE + 1; m_vx = -faster(mag); m_hit = 1;
          end else if (nx + SIZE - 1 >= WIDTH - 1) begin
            m_left = WIDTH - SIZE; m_sl = 1; m_mode = 2; m_hold = SCORE_HOLD;
          end else m_left = nx;
        end
      end
    end else begin
      if (bus.move) begin
        m_hold--;
        if (m_hold == 0) begin
          m_mode = 0; m_left = CX; m_top = CY; m_vx = 0; m_vy = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("top",        int'(bus.top),        m_top);
    chk("left",       int'(bus.left),       m_left);
    chk("bottom",     int'(bus.bottom),     m_top + SIZE - 1);
    chk("right",      int'(bus.right),      m_left + SIZE - 1);
    chk("inPlay",     int'(bus.inPlay),     int'(m_mode == 1));
    chk("paddleHit",  int'(bus.paddleHit),  m_hit);
    chk("scoreLeft",  int'(bus.scoreLeft),  m_sl);
    chk("scoreRight", int'(bus.scoreRight), m_sr);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mv, input bit sv, input bit dir);
    bus.move = mv; bus.serve = sv; bus.serveDir = dir;
    cyc();
    bus.move = 1'b0; bus.serve = 1'b0;
  endtask

  function automatic logic [YW-1:0] track(input int t);
    int v;
    v = t;
    if (v < 0) v = 0;
    if (v > HEIGHT - PADDLE_H) v = HEIGHT - PADDLE_H;
    return YW'(v);
  endfunction

  initial begin
    bit seen;
    fork
      forever begin
        @(posedge clk);
        model_step();
      end
      forever begin
        @(negedge clk);
        if (cmp_en) compare_all();
      end
    join_none

    bus.move = 1'b0; bus.serve = 1'b0; bus.serveDir = 1'b0;
    bus.leftPaddleTop = '0; bus.rightPaddleTop = YW'(30);
    resetN = 1'b0;
    cyc(); cyc();
    cmp_en = 1;
    chk("rst_left", int'(bus.left), 30);
    chk("rst_top", int'(bus.top), 22);
    chk("rst_inPlay", int'(bus.inPlay), 0);
    resetN = 1'b1;

    // Serve right with a simultaneous move: position must hold.
    drive(1, 1, 1);
    chk("serve_left", int'(bus.left), 30);
    chk("serve_inPlay", int'(bus.inPlay), 1);
    repeat (3) drive(1, 0, 0);
    chk("mv3_left", int'(bus.left), 36);
    chk("mv3_top", int'(bus.top), 25);
    drive(1, 1, 0);  // serve while moving is ignored
    repeat (8) drive(1, 0, 0);
    chk("pre_hit_left", int'(bus.left), 54);
    drive(1, 0, 0);
    chk("rhit_left", int'(bus.left), 56);
    chk("rhit_top", int'(bus.top), 35);
    chk("rhit_pulse", int'(bus.paddleHit), 1);
    drive(0, 0, 0);
    chk("rhit_pulse_end", int'(bus.paddleHit), 0);
`ifndef PONG_BALL_SPEEDUP_EN
    repeat (9) drive(1, 0, 0);
    chk("floor_top", int'(bus.top), 44);
    chk("floor_left", int'(bus.left), 38);
    drive(1, 0, 0);
    chk("rise_top", int'(bus.top), 43);
    chk("rise_left", int'(bus.left), 36);
`endif
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      drive(1, 0, 0);
      if (bus.scoreRight) seen = 1;
    end
    chk("scoreRight_seen", int'(seen), 1);
    chk("score_left", int'(bus.left), 0);
    chk("score_inPlay", int'(bus.inPlay), 0);
    drive(0, 1, 1);  // serve while scored is ignored
    chk("scored_serve_left", int'(bus.left), 0);
    repeat (7) drive(1, 0, 0);
    chk("hold7_left", int'(bus.left), 0);
    drive(1, 0, 0);
    chk("idle_left", int'(bus.left), 30);
    chk("idle_top", int'(bus.top), 22);
    chk("idle_inPlay", int'(bus.inPlay), 0);

    // Left paddle catch, then reset in the middle of play.
    bus.leftPaddleTop = YW'(30);
    drive(1, 1, 0);
    repeat (12) drive(1, 0, 0);
    chk("lpre_left", int'(bus.left), 6);
    chk("lpre_top", int'(bus.top), 34);
    drive(1, 0, 0);
    chk("lhit_left", int'(bus.left), 4);
    chk("lhit_pulse", int'(bus.paddleHit), 1);
`ifndef PONG_BALL_SPEEDUP_EN
    drive(1, 0, 0);
    chk("lhit_away_left", int'(bus.left), 6);
`endif
    resetN = 1'b0;
    bus.move = 1'b1;
    cyc();
    bus.move = 1'b0;
    chk("midrst_left", int'(bus.left), 30);
    chk("midrst_top", int'(bus.top), 22);
    chk("midrst_inPlay", int'(bus.inPlay), 0);
    chk("midrst_hit", int'(bus.paddleHit), 0);
    resetN = 1'b1;

    // Randomized play; paddles mostly track the ball so hits happen.
    for (int i = 0; i < 4000; i++) begin
      resetN = ($urandom_range(0, 599) != 0);
      bus.move = ($urandom_range(0, 2) != 0);
      bus.serve = ($urandom_range(0, 5) == 0);
      bus.serveDir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        bus.leftPaddleTop = track(m_top - int'($urandom_range(0, 10)));
        bus.rightPaddleTop = track(m_top - int'($urandom_range(0, 10)));
      end else begin
        bus.leftPaddleTop = YW'($urandom_range(0, HEIGHT - PADDLE_H));
        bus.rightPaddleTop = YW'($urandom_range(0, HEIGHT - PADDLE_H));
      end
      cyc();
    end
    resetN = 1'b1;
    bus.move = 1'b0;
    bus.serve = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pong_ball.md
Name: pong_ball

Overview:
- Parametrised successor to the single-size bouncing square ball. Runs in the system clock domain; steps one position per single-cycle `move` strobe.
- Adds serve/score sequencing and collision with two player paddles. Reports hit and score events.
- Sits between the game-tick generator and the pixel renderer / score keeper of the pong top level.

Parameters:
- WIDTH, 64, playfield width in pixels (columns 0..WIDTH-1)
- HEIGHT, 48, playfield height in pixels (rows 0..HEIGHT-1)
- SIZE, 4, ball edge length in pixels
- X_SPEED, 2, initial horizontal speed magnitude per move
- Y_SPEED, 1, vertical speed magnitude per move
- PADDLE_X, 2, distance of each paddle's outer column from its wall
- PADDLE_W, 2, paddle width in pixels
- PADDLE_H, 12, paddle height in pixels
- SCORE_HOLD, 8, move strobes spent in SCORED before returning to IDLE
- MAX_SPEED, 4, horizontal speed cap (used only with PONG_BALL_SPEEDUP_EN)

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- move  in  1  single-cycle step strobe
- serve  in  1  single-cycle launch request
- serveDir  in  1  0 = launch toward left, 1 = launch toward right
- leftPaddleTop  in  $clog2(HEIGHT)  top row of left paddle
- rightPaddleTop  in  $clog2(HEIGHT)  top row of right paddle
- top  out  $clog2(HEIGHT)  ball top row, registered
- left  out  $clog2(WIDTH)  ball left column, registered
- bottom  out  $clog2(HEIGHT)  top+SIZE-1, combinational
- right  out  $clog2(WIDTH)  left+SIZE-1, combinational
- inPlay  out  1  high in MOVING
- paddleHit  out  1  one-cycle pulse on paddle bounce
- scoreLeft  out  1  one-cycle pulse, ball passed right wall (left player scores)
- scoreRight  out  1  one-cycle pulse, ball passed left wall (right player scores)

Behaviour:
- Reset (resetN low at posedge clk):
  - state=IDLE; left=(WIDTH-SIZE)/2; top=(HEIGHT-SIZE)/2.
  - xVel=0, yVel=0; all pulses 0. Overrides every other input.
- Velocities are signed registers wide enough for ±MAX_SPEED. All position arithmetic uses a signed next-position with one guard bit; no wrap-around permitted.
- Default-parameter center is left=30, top=22.
- IDLE:
  - Ball held at center; move ignored.
  - serve=1 -> MOVING next cycle; xVel=serveDir ? +X_SPEED : -X_SPEED; yVel=+Y_SPEED.
  - Position does not change on the serve cycle, even if move is also high.
- MOVING, on move=1: nx=left+xVel, ny=top+yVel. Vertical and horizontal rules are evaluated in the same cycle.
  - Vertical:
    - ny<=0 -> top=0, yVel=+Y_SPEED.
    - ny+SIZE-1>=HEIGHT-1 -> top=HEIGHT-SIZE, yVel=-Y_SPEED.
    - Otherwise top=ny.
  - Left side (xVel<0):
    - Left paddle face is column LF=PADDLE_X+PADDLE_W.
    - Hit if nx<=LF, left>=LF, and rows [ny,ny+SIZE-1] overlap [leftPaddleTop, leftPaddleTop+PADDLE_H-1].
    - On hit: left=LF, xVel=+|xVel|, paddleHit=1.
    - Otherwise, if nx<=0: left=0, scoreRight=1, state=SCORED.
    - Otherwise left=nx.
  - Right side (xVel>0): mirror of the left side.
    - Right paddle face is RF=WIDTH-1-PADDLE_X-PADDLE_W; hit when nx+SIZE-1>=RF with overlap on rightPaddleTop.
    - On hit: left=RF-SIZE+1, xVel=-|xVel|, paddleHit=1.
    - nx+SIZE-1>=WIDTH-1 -> left=WIDTH-SIZE, scoreLeft=1, state=SCORED.
  - Once the ball is behind a paddle face, it cannot be hit; it continues to the wall.
  - serve ignored in MOVING.
- SCORED:
  - Ball frozen at the wall; an internal counter counts move strobes.
  - After SCORE_HOLD strobes -> IDLE; ball re-centred and velocities zeroed in the same cycle.
  - serve ignored.
- Pulses are registered: high exactly one cycle, in the cycle after the triggering move.
- Reset mid-MOVING or mid-SCORED returns to IDLE at center; pending pulses are cleared.

Optional Feature:
- PONG_BALL_SPEEDUP_EN defined:
  - Each paddle hit increments |xVel| by 1, saturating at MAX_SPEED.
  - Serve reloads X_SPEED.
- Undefined: |xVel| stays X_SPEED; MAX_SPEED unused.

Test Plan:
- Reset while MOVING -> next cycle left=30, top=22, inPlay=0, all pulses 0.
- IDLE, serve=1 with serveDir=1 and move=1 the same cycle -> left stays 30; then 3 move strobes -> left=36, top=25, inPlay=1.
- Ball descending to ny=45 (bottom would reach 48) -> top clamped to 44, yVel=-1; on the next move top=43.
- Left-moving ball at left=5, top=20, leftPaddleTop=18 -> after move left=4, xVel=+2, paddleHit pulse for one cycle.
  - Same case with leftPaddleTop=40 -> ball reaches left=0, scoreRight pulse.
  - Then 8 move strobes -> IDLE with left=30, top=22.
- serve pulses during MOVING and SCORED -> no change in state or velocity.
- With PONG_BALL_SPEEDUP_EN, 4 consecutive paddle hits from X_SPEED=2 -> |xVel| sequence 3, 4, 4, 4.
